// File: rtl/fadd_tree_acc_if.sv
// Beat/result bus between the MAC array and fadd_tree_acc.
// master: drives lane data, mask, sideband and odata_ready.
// slave : fadd_tree_acc; drives in_ready, odata, odata_valid, odata_last, busy.
interface fadd_tree_acc_if #(
   parameter int unsigned DATA_BIT = 16,
   parameter int unsigned MAC_NUM  = 8
);
   logic                         in_valid;
   logic                         in_ready;
   logic [MAC_NUM-1:0]           in_mask;
   logic [DATA_BIT*MAC_NUM-1:0]  idata;
   logic                         in_last;
   logic                         in_acc;
   logic [DATA_BIT-1:0]          odata;
   logic                         odata_valid;
   logic                         odata_ready;
   logic                         odata_last;
   logic                         busy;

   modport master (
      output in_valid, in_mask, idata, in_last, in_acc, odata_ready,
      input  in_ready, odata, odata_valid, odata_last, busy
   );

   modport slave (
      input  in_valid, in_mask, idata, in_last, in_acc, odata_ready,
      output in_ready, odata, odata_valid, odata_last, busy
   );
endinterface

// File: rtl/fadd_tree_acc.sv
// Pipelined floating-point adder tree reducing MAC_NUM lanes to one float per
// beat, with optional per-packet accumulation up to in_last.
// Ports: clk, rstn (async, active-low), bus (fadd_tree_acc_if.slave):
//   in_valid/in_ready beat handshake, in_mask lane enables, idata lanes,
//   in_last/in_acc beat sideband, odata/odata_valid/odata_ready/odata_last
//   result handshake, busy = beats in flight or packet open.
module fadd_tree_acc #(
   parameter int unsigned sig_width  = 7,
   parameter int unsigned exp_width  = 8,
   parameter int unsigned MAC_NUM    = 8,
   parameter int unsigned PIPE_EVERY = 1,
   parameter int unsigned DATA_BIT   = sig_width + exp_width + 1
) (
   input logic            clk,
   input logic            rstn,
   fadd_tree_acc_if.slave bus
);
   localparam int unsigned L  = $clog2(MAC_NUM);
   localparam int unsigned P  = 1 << L;
   localparam int unsigned NR = (L - 1) / PIPE_EVERY;
   localparam int unsigned T  = 1 + NR;
   localparam int unsigned CW = $clog2(T + 2);
   localparam int unsigned MW = sig_width + 4;

   // Round-to-nearest-even add; denormal inputs and underflowing results flush to zero.
   function automatic logic [DATA_BIT-1:0] fp_add(input logic [DATA_BIT-1:0] a,
                                                  input logic [DATA_BIT-1:0] b);
      logic [DATA_BIT-1:0]  x, y, t;
      logic [exp_width-1:0] ex, ey;
      logic [MW-1:0]        mx, my;
      logic [MW:0]          s;
      logic [sig_width+1:0] mr;
      logic                 rnd;
      int unsigned          d;
      int                   e;
      x = (a[DATA_BIT-2 -: exp_width] == '0) ? {a[DATA_BIT-1], {(DATA_BIT-1){1'b0}}} : a;
      y = (b[DATA_BIT-2 -: exp_width] == '0) ? {b[DATA_BIT-1], {(DATA_BIT-1){1'b0}}} : b;
      if (x[DATA_BIT-2:0] < y[DATA_BIT-2:0]) begin
         t = x;
         x = y;
         y = t;
      end
      ex = x[DATA_BIT-2 -: exp_width];
      ey = y[DATA_BIT-2 -: exp_width];
      if (ey == '0) return (ex == '0) ? '0 : x;
      // hidden bit, fraction, then guard/round/sticky positions
      mx = {1'b1, x[sig_width-1:0], 3'b000};
      my = {1'b1, y[sig_width-1:0], 3'b000};
      d  = 32'(ex) - 32'(ey);
      // align: bit 0 collects everything shifted past it as sticky
      for (int unsigned i = 0; i < MW; i++)
         if (i < d) my = {1'b0, my[MW-1:1]} | {{(MW-1){1'b0}}, my[0]};
      s = (x[DATA_BIT-1] == y[DATA_BIT-1]) ? ({1'b0, mx} + {1'b0, my})
                                           : ({1'b0, mx} - {1'b0, my});
      if (s == '0) return '0;
      e = 32'(ex);
      if (s[MW]) begin
         s = {1'b0, s[MW:1]} | {{MW{1'b0}}, s[0]};
         e = e + 1;
      end else begin
         for (int unsigned i = 0; i < MW; i++)
            if (!s[MW-1]) begin
               s = {s[MW-1:0], 1'b0};
               e = e - 1;
            end
      end
      rnd = s[2] && (s[1] || s[0] || s[3]);
      mr  = {1'b0, s[MW-1:3]} + (sig_width+2)'(rnd);
      if (mr[sig_width+1]) e = e + 1;
      if (e <= 0) return {x[DATA_BIT-1], {(DATA_BIT-1){1'b0}}};
      if (e >= (1 << exp_width) - 1) return {x[DATA_BIT-1], {exp_width{1'b1}}, {sig_width{1'b0}}};
      return {x[DATA_BIT-1], exp_width'(e), mr[sig_width-1:0]};
   endfunction

   logic [DATA_BIT-1:0] st_q [NR+1][P];
   logic [DATA_BIT-1:0] st_d [NR+1][P];
   logic [NR:0]         vld_q, vld_d, lst_q, lst_d, amd_q, amd_d;
   logic [DATA_BIT-1:0] odata_q, odata_d, accum_q, accum_d;
   logic                odata_valid_q, odata_valid_d, odata_last_q, odata_last_d;
   logic                open_q, open_d, busy_q, busy_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [DATA_BIT-1:0] cur [P];
   logic [DATA_BIT-1:0] tree_r, acc_sum;
   logic                en_c, inc_c, dec_c;

   // Global stall: everything advances only when the output slot is free.
   assign en_c         = !odata_valid_q || bus.odata_ready;
   assign bus.in_ready = en_c;

   // Tree levels, stage registers, output/accumulator stage and in-flight count.
   always_comb begin
      st_d          = st_q;
      vld_d         = vld_q;
      lst_d         = lst_q;
      amd_d         = amd_q;
      odata_d       = odata_q;
      odata_valid_d = odata_valid_q;
      odata_last_d  = odata_last_q;
      accum_d       = accum_q;
      open_d        = open_q;
      inc_c         = bus.in_valid && en_c;
      dec_c         = en_c && vld_q[NR];

      // Reduce in place; at a stage boundary capture the partials and
      // continue from the registered copy.
      cur = st_q[0];
      for (int unsigned lv = 0; lv < L; lv++) begin
         for (int unsigned j = 0; j < P / 2; j++)
            if (j < (P >> (lv + 1))) cur[j] = fp_add(cur[2*j], cur[2*j+1]);
         if ((lv + 1 < L) && ((lv + 1) % PIPE_EVERY == 0)) begin
            if (en_c) st_d[(lv + 1) / PIPE_EVERY] = cur;
            cur = st_q[(lv + 1) / PIPE_EVERY];
         end
      end
      tree_r  = cur[0];
      acc_sum = fp_add(accum_q, tree_r);

      if (en_c) begin
         // Stage 0: masked lanes and the zero padding up to P.
         for (int unsigned k = 0; k < P; k++) st_d[0][k] = '0;
         for (int unsigned k = 0; k < MAC_NUM; k++)
            if (bus.in_mask[k]) st_d[0][k] = bus.idata[k*DATA_BIT +: DATA_BIT];
         vld_d[0] = bus.in_valid;
         lst_d[0] = bus.in_last;
         amd_d[0] = bus.in_acc;
         for (int unsigned s = 1; s <= NR; s++) begin
            vld_d[s] = vld_q[s-1];
            lst_d[s] = lst_q[s-1];
            amd_d[s] = amd_q[s-1];
         end

         odata_valid_d = 1'b0;
         odata_last_d  = 1'b0;
         if (vld_q[NR]) begin
            if (!amd_q[NR]) begin
               odata_d       = tree_r;
               odata_valid_d = 1'b1;
               odata_last_d  = lst_q[NR];
            end else if (!lst_q[NR]) begin
               accum_d = acc_sum;
               open_d  = 1'b1;
            end else begin
               odata_d       = acc_sum;
               odata_valid_d = 1'b1;
               odata_last_d  = 1'b1;
               accum_d       = '0;
               open_d        = 1'b0;
            end
         end
      end

      cnt_d  = cnt_q + CW'(inc_c) - CW'(dec_c);
      busy_d = (cnt_d != '0) || open_d;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_q         <= '0;
         lst_q         <= '0;
         amd_q         <= '0;
         odata_q       <= '0;
         odata_valid_q <= 1'b0;
         odata_last_q  <= 1'b0;
         accum_q       <= '0;
         open_q        <= 1'b0;
         cnt_q         <= '0;
         busy_q        <= 1'b0;
      end else begin
         vld_q         <= vld_d;
         lst_q         <= lst_d;
         amd_q         <= amd_d;
         odata_q       <= odata_d;
         odata_valid_q <= odata_valid_d;
         odata_last_q  <= odata_last_d;
         accum_q       <= accum_d;
         open_q        <= open_d;
         cnt_q         <= cnt_d;
         busy_q        <= busy_d;
      end
   end

   // Datapath stages need no reset; their valid bits qualify them.
   always_ff @(posedge clk) begin
      st_q <= st_d;
   end

   assign bus.odata       = odata_q;
   assign bus.odata_valid = odata_valid_q;
   assign bus.odata_last  = odata_last_q;
   assign bus.busy        = busy_q;
endmodule

// File: tb/tb_fadd_tree_acc.sv
// Scoreboard bench for fadd_tree_acc: three builds (8 lanes/every level,
// 8 lanes/every 2 levels, 6 lanes) driven one at a time from shared stimulus.
// Lanes carry small integers so every sum is exact in bfloat16.
module tb_fadd_tree_acc;
   typedef struct {
      logic [15:0] data;
      logic        last;
      int          acc_cyc;
      logic        chk_lat;
   } sb_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int           n_vec = 0;
   int           n_err = 0;
   int           sel = 0;
   logic         in_valid = 1'b0;
   logic [7:0]   mask = '0;
   logic         last = 1'b0;
   logic         acc_m = 1'b0;
   logic [127:0] idata8 = '0;
   logic         o_rdy = 1'b1;
   int           bp_mode = 0;
   int           bp_ph = 0;
   int           lane_v [8];
   int           run [3] = '{0, 0, 0};
   int           lat_exp [3] = '{4, 3, 4};
   sb_t          sbq [3][$];
   logic         hold_p [3] = '{1'b0, 1'b0, 1'b0};
   logic [15:0]  hold_d [3];

   fadd_tree_acc_if #(.DATA_BIT(16), .MAC_NUM(8)) if_a ();
   fadd_tree_acc_if #(.DATA_BIT(16), .MAC_NUM(8)) if_b ();
   fadd_tree_acc_if #(.DATA_BIT(16), .MAC_NUM(6)) if_c ();

   fadd_tree_acc #(.sig_width(7), .exp_width(8), .MAC_NUM(8), .PIPE_EVERY(1), .DATA_BIT(16))
      u_dut_a (.clk(clk), .rstn(rstn), .bus(if_a.slave));
   fadd_tree_acc #(.sig_width(7), .exp_width(8), .MAC_NUM(8), .PIPE_EVERY(2), .DATA_BIT(16))
      u_dut_b (.clk(clk), .rstn(rstn), .bus(if_b.slave));
   fadd_tree_acc #(.sig_width(7), .exp_width(8), .MAC_NUM(6), .PIPE_EVERY(1), .DATA_BIT(16))
      u_dut_c (.clk(clk), .rstn(rstn), .bus(if_c.slave));

   assign if_a.in_valid = in_valid && (sel == 0);
   assign if_b.in_valid = in_valid && (sel == 1);
   assign if_c.in_valid = in_valid && (sel == 2);
   assign if_a.in_mask = mask;
   assign if_b.in_mask = mask;
   assign if_c.in_mask = mask[5:0];
   assign if_a.idata = idata8;
   assign if_b.idata = idata8;
   assign if_c.idata = idata8[95:0];
   assign if_a.in_last = last;
   assign if_b.in_last = last;
   assign if_c.in_last = last;
   assign if_a.in_acc = acc_m;
   assign if_b.in_acc = acc_m;
   assign if_c.in_acc = acc_m;
   assign if_a.odata_ready = o_rdy;
   assign if_b.odata_ready = o_rdy;
   assign if_c.odata_ready = o_rdy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Exact bfloat16 encoding of an integer 0..255.
   function automatic logic [15:0] int_to_bf(input int n);
      int p;
      int mant;
      if (n == 0) return 16'h0000;
      p = 0;
      for (int i = 0; i < 8; i++) if (n >= (1 << i)) p = i;
      mant = (n - (1 << p)) << (7 - p);
      return {1'b0, 8'(127 + p), 7'(mant)};
   endfunction

   function automatic logic ready_of(input int d);
      return (d == 0) ? if_a.in_ready : (d == 1) ? if_b.in_ready : if_c.in_ready;
   endfunction

   function automatic logic busy_of(input int d);
      return (d == 0) ? if_a.busy : (d == 1) ? if_b.busy : if_c.busy;
   endfunction

   // Backpressure source: steady, 1-0-0 pattern, or random.
   always @(negedge clk) begin
      if (bp_mode == 0) o_rdy = 1'b1;
      else if (bp_mode == 1) begin
         o_rdy = (bp_ph == 0);
         bp_ph = (bp_ph + 1) % 3;
      end else o_rdy = 1'($urandom_range(0, 1));
   end

   task automatic mon(input int d, input logic v, input logic [15:0] od, input logic ol,
                      input logic ir);
      sb_t e;
      check("in_ready", 32'(ir), 32'(!v || o_rdy));
      if (hold_p[d]) begin
         check("hold_valid", 32'(v), 32'd1);
         check("hold_data", 32'(od), 32'(hold_d[d]));
      end
      hold_p[d] = v && !o_rdy;
      hold_d[d] = od;
      if (v && o_rdy) begin
         check("out_expected", 32'(sbq[d].size() != 0), 32'd1);
         if (sbq[d].size() != 0) begin
            e = sbq[d].pop_front();
            check("odata", 32'(od), 32'(e.data));
            check("odata_last", 32'(ol), 32'(e.last));
            if (e.chk_lat) check("latency", 32'(cyc - e.acc_cyc), 32'(lat_exp[d]));
         end
      end
   endtask

   always @(negedge clk) begin
      #2;
      if (rstn) begin
         mon(0, if_a.odata_valid, if_a.odata, if_a.odata_last, if_a.in_ready);
         mon(1, if_b.odata_valid, if_b.odata, if_b.odata_last, if_b.in_ready);
         mon(2, if_c.odata_valid, if_c.odata, if_c.odata_last, if_c.in_ready);
      end else begin
         for (int d = 0; d < 3; d++) hold_p[d] = 1'b0;
      end
   end

   task automatic push(input int d, input int v, input logic lst, input logic lat);
      sb_t e;
      e.data    = int_to_bf(v);
      e.last    = lst;
      e.acc_cyc = cyc;
      e.chk_lat = lat;
      sbq[d].push_back(e);
   endtask

   // Offer one beat to DUT d using lane_v; update the model when accepted.
   task automatic send_beat(input int d, input logic [7:0] m, input logic lst,
                            input logic acc, input logic lat);
      int   bsum;
      int   nl;
      logic r;
      @(negedge clk);
      sel = d;
      mask = m;
      last = lst;
      acc_m = acc;
      in_valid = 1'b1;
      for (int k = 0; k < 8; k++) idata8[k*16 +: 16] = int_to_bf(lane_v[k]);
      for (int t = 0; t < 300; t++) begin
         #1;
         r = ready_of(d);
         if (r) break;
         @(negedge clk);
      end
      if (!r) begin
         check("in_ready_timeout", 32'(r), 32'd1);
         return;
      end
      nl = (d == 2) ? 6 : 8;
      bsum = 0;
      for (int k = 0; k < nl; k++) if (m[k]) bsum += lane_v[k];
      if (!acc) push(d, bsum, lst, lat);
      else begin
         run[d] += bsum;
         if (lst) begin
            push(d, run[d], 1'b1, lat);
            run[d] = 0;
         end
      end
   endtask

   task automatic drain(input int d);
      @(negedge clk);
      in_valid = 1'b0;
      for (int t = 0; t < 400; t++) begin
         if (sbq[d].size() == 0) break;
         @(negedge clk);
      end
      check("drain_empty", 32'(sbq[d].size()), 32'd0);
      bp_mode = 0;
      repeat (3) @(negedge clk);
      #1;
      check("busy_idle", 32'(busy_of(d)), 32'd0);
   endtask

   task automatic set_lanes(input int v);
      for (int k = 0; k < 8; k++) lane_v[k] = v;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      set_lanes(0);
      #12;
      check("rst_busy", 32'(if_a.busy), 32'd0);
      check("rst_valid", 32'(if_a.odata_valid), 32'd0);
      check("rst_odata", 32'(if_a.odata), 32'd0);
      check("rst_last", 32'(if_a.odata_last), 32'd0);
      check("rst_in_ready", 32'(if_a.in_ready), 32'd1);
      @(negedge clk);
      rstn = 1'b1;

      // Pass mode, masking, padding and the shallower pipeline.
      set_lanes(1);
      send_beat(0, 8'hFF, 1'b1, 1'b0, 1'b1);
      drain(0);
      send_beat(0, 8'h0F, 1'b1, 1'b0, 1'b1);
      drain(0);
      send_beat(2, 8'hFF, 1'b1, 1'b0, 1'b1);
      drain(2);
      send_beat(1, 8'hFF, 1'b1, 1'b0, 1'b1);
      drain(1);

      // Accumulate: 24.0 then a fresh 16.0 packet.
      for (int b = 0; b < 3; b++) send_beat(0, 8'hFF, 1'(b == 2), 1'b1, 1'b1);
      set_lanes(2);
      send_beat(0, 8'hFF, 1'b1, 1'b1, 1'b1);
      drain(0);

      // Pass beat inside an open packet; all-masked last beat closes a packet.
      set_lanes(1);
      send_beat(0, 8'hFF, 1'b0, 1'b1, 1'b0);
      set_lanes(2);
      send_beat(0, 8'h03, 1'b0, 1'b0, 1'b0);
      set_lanes(1);
      send_beat(0, 8'hFF, 1'b0, 1'b1, 1'b0);
      send_beat(0, 8'hFF, 1'b1, 1'b1, 1'b0);
      send_beat(0, 8'hFF, 1'b0, 1'b1, 1'b0);
      send_beat(0, 8'h00, 1'b1, 1'b1, 1'b0);
      drain(0);

      // Backpressure: 10 back-to-back pass beats, lane0 = k.
      bp_ph = 0;
      bp_mode = 1;
      set_lanes(7);
      for (int k = 1; k <= 10; k++) begin
         lane_v[0] = k;
         send_beat(0, 8'h01, 1'b1, 1'b0, 1'b0);
      end
      drain(0);

      // Random mixed traffic under random backpressure on each build.
      for (int d = 0; d < 3; d++) begin
         bp_mode = 2;
         for (int b = 0; b < 25; b++) begin
            logic a_m;
            logic l_m;
            for (int k = 0; k < 8; k++) lane_v[k] = int'($urandom_range(0, 3));
            a_m = 1'($urandom_range(0, 1));
            l_m = ($urandom_range(0, 3) == 0);
            if (a_m && run[d] > 180) l_m = 1'b1;
            send_beat(d, 8'($urandom), l_m, a_m, 1'b0);
         end
         send_beat(d, 8'h00, 1'b1, 1'b1, 1'b0);
         drain(d);
      end

      // Reset in the middle of an accumulate packet.
      set_lanes(1);
      send_beat(0, 8'hFF, 1'b0, 1'b1, 1'b0);
      send_beat(0, 8'hFF, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      check("busy_open", 32'(if_a.busy), 32'd1);
      @(negedge clk);
      rstn = 1'b0;
      for (int d = 0; d < 3; d++) begin
         run[d] = 0;
         sbq[d].delete();
      end
      for (int t = 0; t < 3; t++) begin
         #1;
         check("busy_in_reset", 32'(if_a.busy), 32'd0);
         check("valid_in_reset", 32'(if_a.odata_valid), 32'd0);
         @(negedge clk);
      end
      rstn = 1'b1;
      send_beat(0, 8'hFF, 1'b1, 1'b1, 1'b1);
      drain(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
